// File: rtl/card_board.sv
// card_board: whole memory-match board, pick handshake and show timer.
// Registered outputs; display lags the state register by one cycle.
module card_board #(
  parameter int NUM_CARDS   = 16,
  parameter int VAL_W       = 4,
  parameter int IDX_W       = 4,
  parameter int SHOW_CYCLES = 50000000,
  parameter int TURN_W      = 8
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       start,
  input  logic [NUM_CARDS*VAL_W-1:0] values,
  input  logic                       pick_valid,
  input  logic [IDX_W-1:0]           pick_idx,
  output logic                       pick_ready,
  output logic                       pick_error,
  output logic [NUM_CARDS*VAL_W-1:0] display,
  output logic [NUM_CARDS-1:0]       removed,
  output logic [IDX_W-1:0]           match_count,
  output logic [TURN_W-1:0]          turns,
  output logic                       result_valid,
  output logic                       result_match,
  output logic                       done
);

  localparam int TMR_W =
    (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD =
    TMR_W'(SHOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] PAIRS =
    IDX_W'(NUM_CARDS / 2);

  typedef enum logic [2:0] {
    IDLE, WAIT_A, WAIT_B, SHOW, DONE
  } state_t;

  state_t                     state_q;
  logic [VAL_W-1:0]           vals_q [NUM_CARDS];
  logic [NUM_CARDS-1:0]       removed_q;
  logic [IDX_W-1:0]           sel_a_q;
  logic [IDX_W-1:0]           sel_b_q;
  logic [TMR_W-1:0]           timer_q;
  logic [IDX_W-1:0]           match_count_q;
  logic [TURN_W-1:0]          turns_q;
  logic                       pick_ready_q;
  logic                       pick_error_q;
  logic                       result_valid_q;
  logic                       result_match_q;
  logic                       done_q;
  logic [NUM_CARDS*VAL_W-1:0] display_q;

  logic                       idx_hit;
  logic                       idx_rem;
  logic [VAL_W-1:0]           val_a;
  logic [VAL_W-1:0]           val_b;
  logic [NUM_CARDS-1:0]       sel_mask;
  logic                       pair_eq;
  logic                       rej_a;
  logic                       rej_b;
  logic                       accept;
  logic [IDX_W-1:0]           mc_inc;
  logic [NUM_CARDS*VAL_W-1:0] display_d;

  // Index lookups, pick validation and next display image.
  always_comb begin
    idx_hit   = 1'b0;
    idx_rem   = 1'b0;
    val_a     = '0;
    val_b     = '0;
    sel_mask  = '0;
    display_d = '0;
    for (int i = 0; i < NUM_CARDS; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        idx_hit = 1'b1;
        idx_rem = removed_q[i];
      end
      if (sel_a_q == IDX_W'(i)) begin
        val_a       = vals_q[i];
        sel_mask[i] = 1'b1;
      end
      if (sel_b_q == IDX_W'(i)) begin
        val_b       = vals_q[i];
        sel_mask[i] = 1'b1;
      end
      unique case (1'b1)
        (state_q == IDLE):
          display_d[i*VAL_W +: VAL_W] = '0;
        (state_q == DONE),
        (state_q != IDLE && state_q != DONE
         && removed_q[i]):
          display_d[i*VAL_W +: VAL_W] = '1;
        default: begin
          if (((state_q == WAIT_B || state_q == SHOW)
               && sel_a_q == IDX_W'(i))
              || (state_q == SHOW
                  && sel_b_q == IDX_W'(i)))
            display_d[i*VAL_W +: VAL_W] = vals_q[i];
          else
            display_d[i*VAL_W +: VAL_W] = '0;
        end
      endcase
    end
    pair_eq = (val_a == val_b);
    rej_a   = !idx_hit || idx_rem;
    rej_b   = rej_a || (pick_idx == sel_a_q);
    accept  = pick_valid && pick_ready_q;
    mc_inc  = match_count_q + IDX_W'(1);
  end

  // Game FSM with its registered status outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      for (int i = 0; i < NUM_CARDS; i++)
        vals_q[i] <= '0;
      removed_q      <= '0;
      sel_a_q        <= '0;
      sel_b_q        <= '0;
      timer_q        <= '0;
      match_count_q  <= '0;
      turns_q        <= '0;
      pick_ready_q   <= 1'b0;
      pick_error_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_match_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      pick_error_q   <= 1'b0;
      result_valid_q <= 1'b0;
      result_match_q <= 1'b0;
      if (start) begin
        for (int i = 0; i < NUM_CARDS; i++)
          vals_q[i] <= values[i*VAL_W +: VAL_W];
        removed_q     <= '0;
        match_count_q <= '0;
        turns_q       <= '0;
        sel_a_q       <= '0;
        sel_b_q       <= '0;
        state_q       <= WAIT_A;
        pick_ready_q  <= 1'b1;
        done_q        <= 1'b0;
      end else begin
        unique case (state_q)
          WAIT_A: begin
            if (accept) begin
              if (rej_a) begin
                pick_error_q <= 1'b1;
              end else begin
                sel_a_q <= pick_idx;
                state_q <= WAIT_B;
              end
            end
          end
          WAIT_B: begin
            if (accept) begin
              if (rej_b) begin
                pick_error_q <= 1'b1;
              end else begin
                sel_b_q      <= pick_idx;
                timer_q      <= TMR_LOAD;
                state_q      <= SHOW;
                pick_ready_q <= 1'b0;
              end
            end
          end
          SHOW: begin
            if (timer_q == '0) begin
              result_valid_q <= 1'b1;
              result_match_q <= pair_eq;
              if (turns_q != '1)
                turns_q <= turns_q + TURN_W'(1);
              if (pair_eq) begin
                removed_q     <= removed_q | sel_mask;
                match_count_q <= mc_inc;
              end
              if (pair_eq && mc_inc == PAIRS) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q      <= WAIT_A;
                pick_ready_q <= 1'b1;
              end
            end else begin
              timer_q <= timer_q - TMR_W'(1);
            end
          end
          IDLE, DONE: ;
          default: ;
        endcase
      end
    end
  end

  // Face codes registered from the previous edge's state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      display_q <= '0;
    else
      display_q <= display_d;
  end

  assign pick_ready   = pick_ready_q;
  assign pick_error   = pick_error_q;
  assign display      = display_q;
  assign removed      = removed_q;
  assign match_count  = match_count_q;
  assign turns        = turns_q;
  assign result_valid = result_valid_q;
  assign result_match = result_match_q;
  assign done         = done_q;

endmodule
